// File: rtl/color_blend_pipe.sv
// Three-stage alpha compositor: multiply, sum with rounding, divide and select.
// A single global stall holds every stage whenever the output is blocked.
module color_blend_pipe #(
    parameter int CW  = 4,
    parameter int NCH = 3,
    parameter int AW  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [NCH*CW-1:0] i_bg_color,
    input  logic [NCH*CW-1:0] i_fg_color,
    input  logic [AW-1:0]     i_fg_alpha,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NCH*CW-1:0] o_color
);

    localparam int PW = CW + AW + 1;
    localparam int M  = (1 << AW) - 1;
    localparam int XW = NCH * CW;
    localparam int SW = NCH * PW;

    localparam logic [PW-1:0] HALF = PW'(M / 2);
    localparam logic [PW-1:0] DIV  = PW'(M);
    localparam logic [CW-1:0] SAT  = {CW{1'b1}};

    typedef enum logic [1:0] {
        MODE_BLEND = 2'd0,
        MODE_ADD   = 2'd1,
        MODE_FG    = 2'd2,
        MODE_BG    = 2'd3
    } mode_t;

    logic adv;

    logic          s1_valid;
    mode_t         s1_mode;
    logic [XW-1:0] s1_fg;
    logic [XW-1:0] s1_bg;
    logic [SW-1:0] s1_pa;
    logic [SW-1:0] s1_pb;

    logic          s2_valid;
    mode_t         s2_mode;
    logic [XW-1:0] s2_fg;
    logic [XW-1:0] s2_bg;
    logic [SW-1:0] s2_sum;

    logic [AW-1:0] ainv;
    logic [SW-1:0] pa_all;
    logic [SW-1:0] pb_all;
    logic [SW-1:0] sum_all;
    logic [XW-1:0] res_all;

    assign adv     = !o_valid || i_ready;
    assign o_ready = i_rst || adv;
    assign ainv    = AW'(M) - i_fg_alpha;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW-1:0] fg1;
        logic [CW-1:0] bg1;
        logic [CW-1:0] fg2;
        logic [CW-1:0] bg2;
        logic [CW-1:0] q;
        logic [CW:0]   asum;
        logic [PW-1:0] pb_sel;
        logic [CW-1:0] res;

        assign fg1 = i_fg_color[k*CW +: CW];
        assign bg1 = i_bg_color[k*CW +: CW];
        assign fg2 = s2_fg[k*CW +: CW];
        assign bg2 = s2_bg[k*CW +: CW];

        assign pa_all[k*PW +: PW] = PW'(fg1) * PW'(i_fg_alpha);
        assign pb_all[k*PW +: PW] = PW'(bg1) * PW'(ainv);

        // Additive mode rounds only the scaled foreground term
        assign pb_sel = (s1_mode == MODE_BLEND) ?
                        s1_pb[k*PW +: PW] : '0;

        assign sum_all[k*PW +: PW] = s1_pa[k*PW +: PW]
                                   + pb_sel + HALF;

        assign q    = CW'(s2_sum[k*PW +: PW] / DIV);
        assign asum = {1'b0, bg2} + {1'b0, q};

        always_comb begin
            res = '0;
            unique case (1'b1)
                (s2_mode == MODE_BLEND): res = q;
                (s2_mode == MODE_ADD):
                    res = asum[CW] ? SAT : asum[CW-1:0];
                (s2_mode == MODE_FG): res = fg2;
                default: res = bg2;
            endcase
        end

        assign res_all[k*CW +: CW] = res;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_BLEND;
            s1_fg    <= '0;
            s1_bg    <= '0;
            s1_pa    <= '0;
            s1_pb    <= '0;
            s2_valid <= 1'b0;
            s2_mode  <= MODE_BLEND;
            s2_fg    <= '0;
            s2_bg    <= '0;
            s2_sum   <= '0;
            o_valid  <= 1'b0;
            o_color  <= '0;
        end else if (adv) begin
            s1_valid <= i_valid;
            s1_mode  <= mode_t'(i_mode);
            s1_fg    <= i_fg_color;
            s1_bg    <= i_bg_color;
            s1_pa    <= pa_all;
            s1_pb    <= pb_all;
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_fg    <= s1_fg;
            s2_bg    <= s1_bg;
            s2_sum   <= sum_all;
            o_valid  <= s2_valid;
            o_color  <= s2_valid ? res_all : '0;
        end
    end

endmodule
